// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared types and constants for the sequential calculator: operation codes,
// controller state encoding and the operand/result widths. Imported by the
// RTL and by the testbench.
// -----------------------------------------------------------------------------
package calc_pkg;

  localparam int OPW  = 8;
  localparam int RESW = 16;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    MUL = 2'b10,
    DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/calc_if.sv
// -----------------------------------------------------------------------------
// calculator_io
// Bundles the request and response handshakes of the calculator.
//   request : in_valid / in_ready, operand_A, operand_B, op_code
//   response: out_valid / out_ready, result, div_by_zero
//   status  : busy
// slave  : the calculator core side.
// master : the producer/consumer side (driver and monitor).
// -----------------------------------------------------------------------------
interface calculator_io;

  logic                       in_valid;
  logic                       in_ready;
  logic [calc_pkg::OPW-1:0]   operand_A;
  logic [calc_pkg::OPW-1:0]   operand_B;
  logic [1:0]                 op_code;
  logic                       out_valid;
  logic                       out_ready;
  logic [calc_pkg::RESW-1:0]  result;
  logic                       div_by_zero;
  logic                       busy;

  modport slave (
    input  in_valid, operand_A, operand_B, op_code, out_ready,
    output in_ready, out_valid, result, div_by_zero, busy
  );

  modport master (
    output in_valid, operand_A, operand_B, op_code, out_ready,
    input  in_ready, out_valid, result, div_by_zero, busy
  );

endinterface

// File: rtl/calc_iter_unit.sv
// -----------------------------------------------------------------------------
// calc_iter_unit
// Shared iterative engine for MUL (shift-add) and DIV (restoring division).
// One work register carries the product, or {remainder, quotient}, and is
// updated once per cycle for ITER iterations.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load operands and perform the first iteration
//   mode_div   : 1 = divide, 0 = multiply (sampled with start)
//   a, b       : multiplier/multiplicand or dividend/divisor
//   done       : one-cycle pulse once the final iteration is in the register
//   res        : MUL -> product, DIV -> {remainder[7:0], quotient[7:0]}
// -----------------------------------------------------------------------------
module calc_iter_unit
  import calc_pkg::*;
#(
  parameter int ITER = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            mode_div,
  input  logic [OPW-1:0]  a,
  input  logic [OPW-1:0]  b,
  output logic            done,
  output logic [RESW-1:0] res
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  logic            run_q,  run_d;
  logic            done_q, done_d;
  logic [CW-1:0]   cnt_q,  cnt_d;
  logic [RESW-1:0] work_q, work_d;
  logic [OPW-1:0]  b_q,    b_d;
  logic            div_q,  div_d;

  // One iteration of either algorithm on the work register.
  //   MUL: work = {acc_hi, multiplier}; add the multiplicand to the upper
  //        half when the multiplier LSB is set, then shift right with carry.
  //   DIV: work = {rem, dividend/quotient}; shift the next dividend bit into
  //        the remainder and subtract the divisor when it fits. The remainder
  //        is always below the divisor, so it never needs a ninth bit.
  function automatic logic [RESW-1:0] step(input logic [RESW-1:0] w,
                                           input logic [OPW-1:0]  d,
                                           input logic            is_div);
    logic [OPW:0] hi;
    logic [OPW:0] sh;
    if (is_div) begin
      sh = w[RESW-1:OPW-1];
      if (sh >= {1'b0, d}) begin
        sh   = sh - {1'b0, d};
        step = {sh[OPW-1:0], w[OPW-2:0], 1'b1};
      end else begin
        step = {sh[OPW-1:0], w[OPW-2:0], 1'b0};
      end
    end else begin
      hi   = {1'b0, w[RESW-1:OPW]} + (w[0] ? {1'b0, d} : '0);
      step = {hi, w[OPW-1:1]};
    end
  endfunction

  always_comb begin
    run_d  = run_q;
    done_d = 1'b0;
    cnt_d  = cnt_q;
    work_d = work_q;
    b_d    = b_q;
    div_d  = div_q;
    if (start) begin
      // The load cycle already performs iteration 0, so the last iteration
      // lands in the register ITER-1 cycles later and done follows it.
      b_d    = b;
      div_d  = mode_div;
      work_d = step({{(RESW-OPW){1'b0}}, a}, b, mode_div);
      cnt_d  = CW'(1);
      run_d  = (ITER > 1);
      done_d = (ITER == 1);
    end else if (run_q) begin
      work_d = step(work_q, b_q, div_q);
      if (cnt_q == CW'(ITER - 1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      run_q  <= run_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
    end
  end

  // Datapath registers carry no reset; they are always loaded by start.
  always_ff @(posedge clk) begin
    work_q <= work_d;
    b_q    <= b_d;
    div_q  <= div_d;
  end

  assign done = done_q;
  assign res  = work_q;

endmodule

// File: rtl/calc_core.sv
// -----------------------------------------------------------------------------
// calc_core
// Sequential calculator. Accepts operands/opcode on a valid/ready handshake,
// computes ADD/SUB in one step and MUL/DIV through calc_iter_unit, then holds
// the 16-bit result on a valid/ready handshake until the consumer takes it.
//   clk, rst_n : clock, asynchronous active-low reset
//   io (slave) : in_valid/in_ready, operand_A, operand_B, op_code,
//                out_valid/out_ready, result, div_by_zero, busy
// -----------------------------------------------------------------------------
module calc_core
  import calc_pkg::*;
#(
  parameter int ITER = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  calculator_io.slave  io
);

  state_e            state_q,     state_d;
  logic [RESW-1:0]   result_q,    result_d;
  logic              dbz_q,       dbz_d;
  logic              out_valid_q, out_valid_d;

  op_e               op;
  logic              b_zero;
  logic              iter_start;
  logic              iter_done;
  logic [RESW-1:0]   iter_res;
  logic signed [RESW-1:0] a_s, b_s, sum_s, diff_s;

  assign op     = op_e'(io.op_code);
  assign b_zero = (io.operand_B == '0);

  // Operands are zero-extended into signed 16-bit so SUB wraps to two's
  // complement (3 - 5 = 16'hFFFE).
  assign a_s    = $signed({{(RESW-OPW){1'b0}}, io.operand_A});
  assign b_s    = $signed({{(RESW-OPW){1'b0}}, io.operand_B});
  assign sum_s  = a_s + b_s;
  assign diff_s = a_s - b_s;

  calc_iter_unit #(.ITER(ITER)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (iter_start),
    .mode_div (op == DIV),
    .a        (io.operand_A),
    .b        (io.operand_B),
    .done     (iter_done),
    .res      (iter_res)
  );

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    dbz_d      = dbz_q;
    iter_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          dbz_d = 1'b0;
          unique case (op)
            ADD: begin
              result_d = sum_s;
              state_d  = DONE;
            end
            SUB: begin
              result_d = diff_s;
              state_d  = DONE;
            end
            MUL: begin
              iter_start = 1'b1;
              state_d    = EXEC;
            end
            DIV: begin
              if (b_zero) begin
                result_d = '1;
                dbz_d    = 1'b1;
                state_d  = DONE;
              end else begin
                iter_start = 1'b1;
                state_d    = EXEC;
              end
            end
          endcase
        end
      end
      EXEC: begin
        if (iter_done) begin
          result_d = iter_res;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      result_q    <= '0;
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      dbz_q       <= dbz_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign io.in_ready    = (state_q == IDLE);
  assign io.busy        = (state_q != IDLE);
  assign io.out_valid   = out_valid_q;
  assign io.result      = result_q;
  assign io.div_by_zero = dbz_q;

endmodule
